mult_bank_drain: RTL and testbench

//  Reader-side companion of the two-bank multiplier result store. On start, snapshots the

---
 rtl/mult_bank_drain_if.sv | 46 ++++
 rtl/mult_bank_drain.sv | 179 +++++++++++++++++
 tb/tb_mult_bank_drain.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_bank_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_bank_drain_if
// Description : Valid/ready stream carrying drained result words and their
//               write-back addresses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   m_valid  producer -> consumer  beat present on m_data/m_addr/m_last
//   m_ready  consumer -> producer  beat taken when m_valid && m_ready
//   m_data   producer -> consumer  DATA_W result word
//   m_addr   producer -> consumer  ADDR_W write-back address of m_data
//   m_last   producer -> consumer  final beat of the drain
// Modports
//   master   drives the stream (the drain engine)
//   slave    consumes the stream (writeback / memory path)
// ============================================================================
interface mult_bank_drain_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_addr,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_addr,
    input  m_last,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/mult_bank_drain.sv
`default_nettype none
// ============================================================================
// Module      : mult_bank_drain
// Description : Reader-side companion of the two-bank multiplier result store.
//               On start it snapshots the eight stored words and streams the
//               enabled banks one word per accepted beat, each tagged with a
//               compact sequential write-back address, then pulses done.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       clock, all logic on rising edge
//   rst_n        in   1       synchronous active-low reset
//   start_i      in   1       drain request, sampled only when idle
//   bank_mask_i  in   2       bit0 = emit bank0 words, bit1 = emit bank1 words
//   base_addr_i  in   ADDR_W  address of the first emitted word
//   in1_i..in4_i in   DATA_W  bank0 lanes 0..3
//   in5_i..in8_i in   DATA_W  bank1 lanes 0..3
//   m_if         master       valid/ready output stream (data, addr, last)
//   busy_o       out  1       high whenever not idle
//   done_o       out  1       one-cycle pulse after the final beat is taken
// ============================================================================
module mult_bank_drain #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start_i,
  input  wire logic [1:0]        bank_mask_i,
  input  wire logic [ADDR_W-1:0] base_addr_i,
  input  wire logic [DATA_W-1:0] in1_i,
  input  wire logic [DATA_W-1:0] in2_i,
  input  wire logic [DATA_W-1:0] in3_i,
  input  wire logic [DATA_W-1:0] in4_i,
  input  wire logic [DATA_W-1:0] in5_i,
  input  wire logic [DATA_W-1:0] in6_i,
  input  wire logic [DATA_W-1:0] in7_i,
  input  wire logic [DATA_W-1:0] in8_i,
  mult_bank_drain_if.master      m_if,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(ADDR_STEP);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] snap_q [8];
  logic [DATA_W-1:0] snap_d [8];
  logic [1:0]        mask_q, mask_d;
  logic [2:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] w_in [8];
  logic [2:0]        w_idx_nxt;
  logic [2:0]        w_last_idx;

  assign w_in = '{in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i, in8_i};

  // Enabled words always form one contiguous run (0..3, 4..7 or 0..7), so
  // the next word is simply idx+1; the masked bank is skipped by choosing
  // the start index and the final index.
  assign w_idx_nxt  = idx_q + 3'd1;
  assign w_last_idx = (mask_q == 2'b01) ? 3'd3 : 3'd7;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          snap_d = w_in;
          mask_d = bank_mask_i;
          busy_d = 1'b1;
          if (bank_mask_i == 2'b00) begin
            // Nothing to emit: report completion straight away.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // First beat is loaded from the live inputs in the same edge the
            // snapshot is taken, so m_valid appears one cycle after start.
            state_d = S_SEND;
            idx_d   = bank_mask_i[0] ? 3'd0 : 3'd4;
            valid_d = 1'b1;
            data_d  = bank_mask_i[0] ? in1_i : in5_i;
            addr_d  = base_addr_i;
            last_d  = 1'b0;
          end
        end
      end

      S_SEND: begin
        if (valid_q && m_if.m_ready) begin
          if (last_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Address advances per emitted beat, independent of lane number.
            idx_d  = w_idx_nxt;
            data_d = snap_q[w_idx_nxt];
            addr_d = addr_q + C_STEP;
            last_d = (w_idx_nxt == w_last_idx);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        snap_q[i] <= '0;
      end
      mask_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign m_if.m_valid = valid_q;
  assign m_if.m_data  = data_q;
  assign m_if.m_addr  = addr_q;
  assign m_if.m_last  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_bank_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_bank_drain
// Description : Self-checking bench for mult_bank_drain. Expected beats are
//               queued when a drain is started and compared against beats
//               observed on the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_bank_drain;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [1:0]    bank_mask_i;
  logic [AW-1:0] base_addr_i;
  logic [DW-1:0] in_w [8];
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  beat_t exp_q [$];
  beat_t obs_q [$];
  int    done_q [$];
  bit    valid_seen;

  mult_bank_drain_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mult_bank_drain #(.DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .bank_mask_i (bank_mask_i),
    .base_addr_i (base_addr_i),
    .in1_i       (in_w[0]),
    .in2_i       (in_w[1]),
    .in3_i       (in_w[2]),
    .in4_i       (in_w[3]),
    .in5_i       (in_w[4]),
    .in6_i       (in_w[5]),
    .in7_i       (in_w[6]),
    .in8_i       (in_w[7]),
    .m_if        (bus),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: records every beat presented with ready, plus done pulses.
  always @(negedge clk) begin
    if (bus.m_valid === 1'b1) valid_seen = 1'b1;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1)
      obs_q.push_back(beat_t'{bus.m_data, bus.m_addr, bus.m_last, 32'(cyc)});
    if (done_o === 1'b1) done_q.push_back(cyc);
  end

  // ---------------- stimulus helpers and reference model ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_words();
    for (int i = 0; i < 8; i++) in_w[i] = 32'h11 * (i + 1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
    valid_seen = 1'b0;
  endtask

  // Start pulse in cycle 0 (returned as c0); returns inside cycle 1.
  task automatic kick(input logic [1:0] mask, input logic [31:0] base, output int c0);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    bank_mask_i = mask;
    base_addr_i = base;
    c0          = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Beats in word order of enabled banks, compact addresses, one beat per
  // cycle from c0+1, with stall_len extra cycles from beat stall_at onward.
  task automatic expect_drain(input logic [1:0] mask, input logic [31:0] base,
                              input int c0, input int stall_at, input int stall_len);
    int b;
    int nb;
    int extra;
    nb = (mask[0] ? 4 : 0) + (mask[1] ? 4 : 0);
    b  = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i / 4]) begin
        b++;
        extra = (stall_at != 0 && b >= stall_at) ? stall_len : 0;
        exp_q.push_back(beat_t'{in_w[i], base + 32'(4 * (b - 1)), (b == nb),
                                32'(c0 + b + extra)});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; bank_mask_i = 2'b11; base_addr_i = 32'h100;
    load_words();
    clear_sb();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.m_last, busy_o, done_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got valid/last/busy/done=%b want 0000",
               {bus.m_valid, bus.m_last, busy_o, done_o});
    end
    checks++;
    if ({bus.m_data, bus.m_addr} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got data=%h addr=%h want 0/0", bus.m_data, bus.m_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_seen || obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b valid_seen=%0d beats=%0d want 0/0/0",
               busy_o, valid_seen, obs_q.size());
    end
  endtask

  task automatic test_full_drain();
    int    c0;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    kick(2'b11, 32'h100, c0);
    expect_drain(2'b11, 32'h100, c0, 0, 0);
    goto(c0 + 10);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got busy=%b want 0", busy_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL full_count got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != c0 + 9) begin
      errors++;
      $display("FAIL full_done got %0d pulses first_rel=%0d want 1 at 9",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - c0 : -1);
    end
  endtask

  task automatic test_backpressure();
    int    c0;
    int    rel;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    kick(2'b11, 32'h100, c0);
    expect_drain(2'b11, 32'h100, c0, 2, 3);
    for (int k = 0; k < 14; k++) begin
      rel = cyc - c0;
      bus.m_ready = !(rel >= 2 && rel <= 4);
      @(negedge clk);
      if (rel >= 2 && rel <= 5) begin
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_addr, bus.m_last} !== {1'b1, 32'h22, 32'h104, 1'b0}) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got v=%b d=%h a=%h l=%b want 1/22/104/0",
                   rel, bus.m_valid, bus.m_data, bus.m_addr, bus.m_last);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bp_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != c0 + 12) begin
      errors++;
      $display("FAIL bp_done got %0d pulses first_rel=%0d want 1 at 12",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - c0 : -1);
    end
  endtask

  task automatic test_masks();
    int    c0;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    kick(2'b10, 32'h200, c0);
    expect_drain(2'b10, 32'h200, c0, 0, 0);
    goto(c0 + 8);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL mask10_count got %0d beats want 4", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mask10_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != c0 + 5) begin
      errors++;
      $display("FAIL mask10_done got %0d pulses first_rel=%0d want 1 at 5",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - c0 : -1);
    end
    // Empty mask: no beats, immediate completion.
    clear_sb();
    kick(2'b00, 32'h300, c0);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, bus.m_valid} !== 3'b110) begin
      errors++;
      $display("FAIL mask00_c1 got busy/done/valid=%b want 110", {busy_o, done_o, bus.m_valid});
    end
    goto(c0 + 6);
    checks++;
    if (valid_seen || done_q.size() != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mask00_after got valid_seen=%0d done_pulses=%0d busy=%b want 0/1/0",
               valid_seen, done_q.size(), busy_o);
    end
  endtask

  task automatic test_snapshot_ignore();
    int    c0;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    kick(2'b11, 32'h100, c0);
    expect_drain(2'b11, 32'h100, c0, 0, 0);
    goto(c0 + 4);
    for (int i = 0; i < 8; i++) in_w[i] = 32'hFF * (i + 1);
    start_i = 1'b1; bank_mask_i = 2'b01; base_addr_i = 32'h900;
    goto(c0 + 5);
    start_i = 1'b0;
    goto(c0 + 9);
    start_i = 1'b1;
    goto(c0 + 10);
    start_i = 1'b0;
    goto(c0 + 18);
    load_words();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL snap_count got %0d beats want 8", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL snap_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL snap_done got %0d pulses busy=%b want 1/0", done_q.size(), busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int    c0;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b1; bank_mask_i = 2'b01; base_addr_i = 32'h40;
    c0 = cyc;
    expect_drain(2'b01, 32'h40, c0, 0, 0);
    expect_drain(2'b01, 32'h40, c0 + 6, 0, 0);
    // start held through SEND/DONE; only the idle cycle after DONE takes it
    goto(c0 + 7);
    start_i = 1'b0;
    goto(c0 + 16);
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d beats want 8", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 2 || done_q[0] != c0 + 5 || done_q[1] != c0 + 11) begin
      errors++;
      $display("FAIL b2b_done got %0d pulses first_rel=%0d want 2 at 5 and 11",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - c0 : -1);
    end
  endtask

  task automatic test_wrap_abort();
    int    c0;
    beat_t e, o;
    clear_sb();
    bus.m_ready = 1'b1;
    kick(2'b11, 32'hFFFF_FFF8, c0);
    expect_drain(2'b11, 32'hFFFF_FFF8, c0, 0, 0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    goto(c0 + 3);
    rst_n = 1'b0;
    goto(c0 + 4);
    @(negedge clk);
    checks++;
    if ({bus.m_valid, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL abort_out got valid/busy=%b want 00", {bus.m_valid, busy_o});
    end
    goto(c0 + 5);
    rst_n = 1'b1;
    goto(c0 + 16);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL wrap_count got %0d beats want 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_beat got d=%h a=%h l=%b c=%0d want d=%h a=%h l=%b c=%0d",
                 o.data, o.addr, o.last, o.cyc - c0, e.data, e.addr, e.last, e.cyc - c0);
      end
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL abort_done got %0d pulses want 0", done_q.size());
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    test_reset();
    test_full_drain();
    test_backpressure();
    test_masks();
    test_snapshot_ignore();
    test_back_to_back();
    test_wrap_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
